// File: rtl/switch_debouncer_if.sv
// Bundles the raw switch inputs, change-clear/IRQ-enable controls and debounced outputs.
// The debouncer connects through the slave modport, and bus logic through the master modport.
interface switch_debouncer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] clr_chg;
    logic             irq_en;
    logic [WIDTH-1:0] switch;
    logic [WIDTH-1:0] sw_chg_pulse;
    logic [WIDTH-1:0] chg_mask;
    logic             irq;

    modport master (
        output sw_raw,
        output clr_chg,
        output irq_en,
        input  switch,
        input  sw_chg_pulse,
        input  chg_mask,
        input  irq
    );

    modport slave (
        input  sw_raw,
        input  clr_chg,
        input  irq_en,
        output switch,
        output sw_chg_pulse,
        output chg_mask,
        output irq
    );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit 2-FF synchroniser followed by a settle FSM and counter. A bit's new level must hold
// for DEBOUNCE_CYCLES before it is committed. Each commit strobes sw_chg_pulse and sets chg_mask.
module switch_debouncer #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input logic               i_clk,
    input logic               i_reset,
    switch_debouncer_if.slave bus
);

    typedef enum logic {
        StStable,
        StSettling
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_switch;
    logic [WIDTH-1:0] r_pulse;
    logic [WIDTH-1:0] r_chg_mask;
    state_e           r_state   [WIDTH];
    logic [CNT_W-1:0] r_cnt     [WIDTH];

    state_e           w_state_d [WIDTH];
    logic [CNT_W-1:0] w_cnt_d   [WIDTH];
    logic [WIDTH-1:0] w_commit;

    always_comb begin
        w_commit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_state_d[i] = r_state[i];
            w_cnt_d[i]   = r_cnt[i];
            unique case (r_state[i])
                StStable: begin
                    w_cnt_d[i] = '0;
                    if (r_s[i] != r_switch[i]) begin
                        w_state_d[i] = StSettling;
                    end
                end
                StSettling: begin
                    if (r_s[i] == r_switch[i]) begin
                        // Bounced back to the old level: drop the settle without a commit.
                        w_state_d[i] = StStable;
                        w_cnt_d[i]   = '0;
                    end else if (r_cnt[i] == CntMax) begin
                        w_commit[i]  = 1'b1;
                        w_state_d[i] = StStable;
                        w_cnt_d[i]   = '0;
                    end else begin
                        w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d[i] = StStable;
                    w_cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1       <= '0;
            r_s        <= '0;
            r_switch   <= '0;
            r_pulse    <= '0;
            r_chg_mask <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= StStable;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_s1       <= bus.sw_raw;
            r_s        <= r_s1;
            r_switch   <= (r_switch & ~w_commit) | (r_s & w_commit);
            r_pulse    <= w_commit;
            // A commit in the same cycle as a clear keeps the mask bit set.
            r_chg_mask <= (r_chg_mask & ~bus.clr_chg) | w_commit;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_d[i];
                r_cnt[i]   <= w_cnt_d[i];
            end
        end
    end

    assign bus.switch       = r_switch;
    assign bus.sw_chg_pulse = r_pulse;
    assign bus.chg_mask     = r_chg_mask;
    assign bus.irq          = bus.irq_en & (|r_chg_mask);

endmodule
